// File: rtl/disp_pkg.sv
// Shared types and helpers for the round-robin dispatcher.
package disp_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } disp_state_e;

    // Bits needed to index n lanes; never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_sel.sv
// Combinational round-robin picker: returns the first set bit of vec,
// scanning upward from last_idx+1 and wrapping, so last_idx ranks lowest.
// WIDTH must be a power of two so the index wraps by plain truncation.
module rr_sel
    import disp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [IDX_W-1:0] probe;

    // Scan lanes in rotated order and keep the first candidate found.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        idx   = '0;
        vld   = 1'b0;
        probe = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            probe = last_idx + IDX_W'(i);
            if (!vld && vec[probe]) begin
                idx = probe;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_rr.sv
// Round-robin dispatcher: takes items from one upstream rdy/ack producer and
// offers each to the next free consumer lane, rotating so that the lane
// served last has the lowest priority.
// Optional build macro DISP_RR_TMO_EN adds a SEND watchdog and sticky err_o.
module disp_rr
    import disp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DISP_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    TMO_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rdy_i,
    output logic                  ack_o,
    input  logic                  free_i [0:DISP_WIDTH-1],
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rdy_o  [0:DISP_WIDTH-1],
    input  logic                  ack_i  [0:DISP_WIDTH-1]
`ifdef DISP_RR_TMO_EN
    ,
    output logic                  err_o
`endif
);

    localparam int IDX_W = idx_width(DISP_WIDTH);

    disp_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DISP_WIDTH-1:0] rdy_q, rdy_d;
    logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]      last_idx_q, last_idx_d;

    logic [DISP_WIDTH-1:0] free_vec;
    logic [DISP_WIDTH-1:0] ack_vec;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_vld;
    logic                  cur_ack;
    logic                  cap;

`ifdef DISP_RR_TMO_EN
    localparam int CNT_W = idx_width(TMO_CYCLES);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    // Flatten the per-lane inputs and fan the offer register out to the lanes.
    always_comb begin
        free_vec = '0;
        ack_vec  = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            free_vec[i] = free_i[i];
            ack_vec[i]  = ack_i[i];
            rdy_o[i]    = rdy_q[i];
        end
    end

    rr_sel #(
        .WIDTH (DISP_WIDTH),
        .IDX_W (IDX_W)
    ) u_rr_sel (
        .vec      (free_vec),
        .last_idx (last_idx_q),
        .idx      (sel_idx),
        .vld      (sel_vld)
    );

    // Capture happens from IDLE, or from SEND on the same edge the current lane acks.
    assign cur_ack = (state_q == SEND) && ack_vec[cur_idx_q];
    assign cap     = rdy_i && sel_vld && ((state_q == IDLE) || cur_ack);
    assign ack_o   = cap;
    assign data_o  = data_q;
`ifdef DISP_RR_TMO_EN
    assign err_o   = err_q;
`endif

    // Next-state logic: capture and offer, release on ack, or drop on watchdog expiry.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rdy_d      = rdy_q;
        cur_idx_d  = cur_idx_q;
        last_idx_d = last_idx_q;
`ifdef DISP_RR_TMO_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
`endif
        if (cap) begin
            data_d         = data_i;
            cur_idx_d      = sel_idx;
            last_idx_d     = sel_idx;
            rdy_d          = '0;
            rdy_d[sel_idx] = 1'b1;
            state_d        = SEND;
`ifdef DISP_RR_TMO_EN
            tmo_cnt_d      = '0;
`endif
        end else if (cur_ack) begin
            rdy_d   = '0;
            state_d = IDLE;
        end
`ifdef DISP_RR_TMO_EN
        else if (state_q == SEND) begin
            if (tmo_cnt_q == CNT_W'(TMO_CYCLES - 1)) begin
                rdy_d   = '0;
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
`endif
    end

    // State register; last_idx resets to all ones so lane 0 is chosen first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            data_q     <= RESET_VAL;
            rdy_q      <= '0;
            cur_idx_q  <= '0;
            last_idx_q <= '1;
`ifdef DISP_RR_TMO_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational block.
            state_q    <= state_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            cur_idx_q  <= cur_idx_d;
            last_idx_q <= last_idx_d;
`ifdef DISP_RR_TMO_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    localparam bit IS_POW2 = (DISP_WIDTH >= 2) && ((DISP_WIDTH & (DISP_WIDTH - 1)) == 0);

    a_width_pow2: assert property (@(posedge clk_i) IS_POW2);

    a_rdy_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rdy_q));

    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == SEND && !cur_ack) |=> $stable(data_q));

    a_ack_needs_rdy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ack_o |-> rdy_i);

endmodule

// File: tb/tb_disp_rr.sv
// Directed self-checking bench for disp_rr (4 lanes, 32-bit data).
module tb_disp_rr;

    localparam int                DW = 32;
    localparam int                NW = 4;
    localparam logic [DW-1:0]     RV = 32'hDEAD_BEEF;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] data_i;
    logic          rdy_i;
    logic          ack_o;
    logic          free_i [0:NW-1];
    logic [DW-1:0] data_o;
    logic          rdy_o  [0:NW-1];
    logic          ack_i  [0:NW-1];
`ifdef DISP_RR_TMO_EN
    logic          err_o;
`endif

    logic [NW-1:0] rdy_v;
    int            checks = 0;
    int            errors = 0;

    disp_rr #(
        .DATA_WIDTH (DW),
        .DISP_WIDTH (NW),
        .RESET_VAL  (RV),
        .TMO_CYCLES (8)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_i (data_i),
        .rdy_i  (rdy_i),
        .ack_o  (ack_o),
        .free_i (free_i),
        .data_o (data_o),
        .rdy_o  (rdy_o),
        .ack_i  (ack_i)
`ifdef DISP_RR_TMO_EN
        ,
        .err_o  (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        rdy_v = '0;
        for (int i = 0; i < NW; i++) rdy_v[i] = rdy_o[i];
    end

    task automatic set_free(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) free_i[i] = v[i];
    endtask

    task automatic set_ack(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) ack_i[i] = v[i];
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        rdy_i  = 1'b0;
        data_i = '0;
        set_free(4'b1111);
        set_ack(4'b0000);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Offer one item at a negedge, check ack_o, then check the registered offer.
    task automatic offer(input string name, input logic [DW-1:0] d,
                         input logic [NW-1:0] free, input logic [NW-1:0] acks,
                         input logic [NW-1:0] exp_rdy);
        @(negedge clk_i);
        data_i = d;
        rdy_i  = 1'b1;
        set_free(free);
        set_ack(acks);
        #1;
        checks++;
        if (ack_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_o: got %b expected 1", name, ack_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (rdy_v !== exp_rdy || data_o !== d) begin
            errors++;
            $display("FAIL %s offer: got rdy_o=%b data_o=%h expected rdy_o=%b data_o=%h",
                     name, rdy_v, data_o, exp_rdy, d);
        end
    endtask

    // Consumer acks the lane with no new item pending; offer must clear.
    task automatic drain(input string name, input logic [NW-1:0] acks);
        @(negedge clk_i);
        rdy_i = 1'b0;
        set_free(4'b1111);
        set_ack(acks);
        @(posedge clk_i);
        #1;
        checks++;
        if (rdy_v !== 4'b0000) begin
            errors++;
            $display("FAIL %s drain: got rdy_o=%b expected 0000", name, rdy_v);
        end
        @(negedge clk_i);
        set_ack(4'b0000);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (rdy_v !== 4'b0000 || data_o !== RV || ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rdy_o=%b data_o=%h ack_o=%b expected 0000 %h 0",
                     rdy_v, data_o, ack_o, RV);
        end
`ifdef DISP_RR_TMO_EN
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset err_o: got %b expected 0", err_o);
        end
`endif
    endtask

    task automatic test_single();
        offer("single", 32'h0000_00A5, 4'b1111, 4'b0000, 4'b0001);
        drain("single", 4'b0001);
    endtask

    task automatic test_back_to_back();
        logic [NW-1:0] exp_lane [0:4];
        logic [NW-1:0] prev;
        exp_lane[0] = 4'b0001;
        exp_lane[1] = 4'b0010;
        exp_lane[2] = 4'b0100;
        exp_lane[3] = 4'b1000;
        exp_lane[4] = 4'b0001;
        do_reset();
        prev = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            offer($sformatf("b2b[%0d]", k), DW'(k + 1), 4'b1111, prev, exp_lane[k]);
            prev = exp_lane[k];
        end
        drain("b2b", 4'b0001);
    endtask

    task automatic test_skip_busy();
        offer("skip_a", 32'h11, 4'b1111, 4'b0000, 4'b0010);
        drain("skip_a", 4'b0010);
        offer("skip_b", 32'h22, 4'b1011, 4'b0000, 4'b1000);
        offer("skip_c", 32'h33, 4'b1111, 4'b1000, 4'b0001);
        drain("skip_c", 4'b0001);
    endtask

    task automatic test_no_free();
        @(negedge clk_i);
        data_i = 32'h77;
        rdy_i  = 1'b1;
        set_free(4'b0000);
        set_ack(4'b0000);
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (ack_o !== 1'b0) begin
                errors++;
                $display("FAIL no_free[%0d] ack_o: got %b expected 0", c, ack_o);
            end
            @(posedge clk_i);
            #1;
            checks++;
            if (rdy_v !== 4'b0000) begin
                errors++;
                $display("FAIL no_free[%0d] rdy_o: got %b expected 0000", c, rdy_v);
            end
            @(negedge clk_i);
        end
        offer("no_free_release", 32'h77, 4'b0010, 4'b0000, 4'b0010);
        drain("no_free", 4'b0010);
    endtask

    task automatic test_ignored_acks();
        offer("ign", 32'h55, 4'b1111, 4'b0000, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            rdy_i = 1'b0;
            set_free(4'b1011);
            set_ack(4'b1011);
            @(posedge clk_i);
            #1;
            checks++;
            if (rdy_v !== 4'b0100 || data_o !== 32'h55) begin
                errors++;
                $display("FAIL ign_hold[%0d]: got rdy_o=%b data_o=%h expected 0100 00000055",
                         c, rdy_v, data_o);
            end
        end
        drain("ign", 4'b0100);
        @(negedge clk_i);
        set_ack(4'b1111);
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (rdy_v !== 4'b0000 || data_o !== 32'h55) begin
            errors++;
            $display("FAIL ign_idle: got rdy_o=%b data_o=%h expected 0000 00000055",
                     rdy_v, data_o);
        end
        @(negedge clk_i);
        set_ack(4'b0000);
    endtask

    task automatic test_stall();
        offer("stall", 32'h66, 4'b1111, 4'b0000, 4'b1000);
        @(negedge clk_i);
        rdy_i = 1'b0;
`ifdef DISP_RR_TMO_EN
        // Capture edge already passed: 7 more held cycles, then the drop.
        for (int c = 0; c < 7; c++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (rdy_v !== 4'b1000 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL tmo_hold[%0d]: got rdy_o=%b err_o=%b expected 1000 0",
                         c, rdy_v, err_o);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (rdy_v !== 4'b0000 || err_o !== 1'b1) begin
                errors++;
                $display("FAIL tmo_drop[%0d]: got rdy_o=%b err_o=%b expected 0000 1",
                         c, rdy_v, err_o);
            end
        end
`else
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (rdy_v !== 4'b1000 || data_o !== 32'h66) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rdy_o=%b data_o=%h expected 1000 00000066",
                         c, rdy_v, data_o);
            end
        end
        drain("stall", 4'b1000);
`endif
    endtask

    initial begin
        rst_ni = 1'b0;
        rdy_i  = 1'b0;
        data_i = '0;
        set_free(4'b1111);
        set_ack(4'b0000);
        test_reset();
        test_single();
        test_back_to_back();
        test_skip_busy();
        test_no_free();
        test_ignored_acks();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
